dmem_resp: RTL
==============

# dmem_resp

Data-memory responder at the far end of the execute stage's load/store request interface. It accepts one load or store per request (read/write enables, byte address, load-type mask, byte-lane write enables, unaligned store data), performs the access on an internal word-organised RAM after a programmable number of wait cycles, and returns sign/zero-extended load data to the memory/write-back side. While an access is in flight it stalls the pipeline, and it flags misaligned accesses instead of performing them.

## Interface
Parameters:
- XLEN, 32, data and address width.
- ADDR_W, 12, word-index width; RAM depth is 2**ADDR_W words.
- WAIT_CYCLES, 1, extra cycles before the RAM access edge; legal range 0..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_re  in  1  load request.
- req_we  in  1  store request.
- req_addr  in  XLEN  byte address.
- req_l_mask  in  5  load type, one-hot: bit0 LB, bit1 LH, bit2 LW, bit3 LBU, bit4 LHU.
- req_byte_we  in  4  store lane enables: 0001/0010/0100/1000 byte, 0011/1100 half, 1111 word.
- req_wdata  in  XLEN  store data, right-aligned (rs2 as read); the block shifts it to the lane.
- req_ready  out  1  high when a request can be accepted; low is the pipeline stall.
- rsp_valid  out  1  one-cycle pulse: access complete.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and misaligned accesses.
- misalign_exp  out  1  one-cycle pulse, coincident with rsp_valid, access was misaligned.
- misalign_addr  out  XLEN  faulting byte address, held until the next response.

## Operation
- Accept: req_ready & (req_re | req_we) at a rising edge captures address, mask, lane enables and wdata into a request register.
- Both req_re and req_we high: treated as a store; the load is ignored.
- req_we with req_byte_we = 0000: accepted, no RAM write, normal response.
- Misalignment: LH/LHU with addr[0]=1; LW with addr[1:0]≠00; half-store with addr[0]=1; word store with addr[1:0]≠00. A misaligned access performs no RAM read or write; it responds at normal latency with misalign_exp=1 and rsp_rdata=0.
- Word index = addr[ADDR_W+1:2]; higher address bits are ignored (aliasing wrap).
- Store: the data lane is wdata[7:0] replicated to all four bytes for byte stores, wdata[15:0] to both halves for half stores, and wdata as-is for word stores. Only bytes with req_byte_we set are written.
- Load: the full word is read, then the byte is selected by addr[1:0] and the half by addr[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- FSM states: IDLE, WAIT.
  - IDLE: on accept, if WAIT_CYCLES=0 the access edge is the accept edge and the FSM stays in IDLE. Otherwise go to WAIT with cnt=0.
  - WAIT: cnt increments each cycle. When cnt=WAIT_CYCLES-1, the access happens at that edge and the FSM returns to IDLE.
- Reset values: state IDLE, cnt 0, req_ready 1, rsp_valid 0, rsp_rdata 0, misalign_exp 0, misalign_addr 0. RAM contents are not reset.
- Reset during WAIT: the pending access is dropped (no RAM write) and no response is produced.

## Timing
- Request presented and accepted in cycle 0. The RAM access occurs at the end of cycle WAIT_CYCLES. rsp_valid, rsp_rdata and misalign_exp are registered and valid in cycle WAIT_CYCLES+1.
- req_ready is low in cycles 1..WAIT_CYCLES and high again in cycle WAIT_CYCLES+1, so a new request may be accepted in the same cycle a response is presented.
- WAIT_CYCLES=0: req_ready stays high, one access per cycle, single-cycle latency.
- Store then load to the same word with WAIT_CYCLES=0 in cycles 0 and 1: the load returns the new data.
- Requests presented while req_ready=0 are ignored. The upstream stage must hold them stable until accepted.

## Structure
- defines.v gains the L_MASK_LB/LH/LW/LBU/LHU bit positions and the byte_we encodings; XLEN comes from there.
- One sub-module, load_ext: combinational lane select plus sign/zero extension (inputs: word, addr[1:0], l_mask).
- RAM is an inferred reg array with a byte-enable write; no reset.

## Test plan
- WAIT_CYCLES=0: SW 0xDEADBEEF @0x10, then LW @0x10 the next cycle -> rsp_valid in the cycle after the LW, rsp_rdata=0xDEADBEEF, req_ready never low.
- SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LH @0x12 -> 0x80AD (sign-extended to 0xFFFF80AD).
- WAIT_CYCLES=3: LW accepted in cycle 0 -> req_ready low in cycles 1–3, rsp_valid in cycle 4; a second LW presented in cycles 1–3 is not accepted until cycle 4.
- LW @0x22 -> misalign_exp=1, misalign_addr=0x22, rsp_rdata=0. SH @0x21 -> misalign_exp=1 and the RAM word at 0x20 is unchanged.
- WAIT_CYCLES=2: rst asserted in cycle 1 of an SW @0x40 -> no rsp_valid, the word at 0x40 keeps its old value, req_ready=1 after the reset edge.
- req_re=req_we=1 with SW @0x8 -> the store is performed; a following LW @0x8 returns the stored value.

Source files
------------

// File: rtl/dmem_resp_pkg.sv
// dmem_resp_pkg: shared constants, FSM states and the misalignment rule for dmem_resp
package dmem_resp_pkg;
    localparam int XLEN_DEF = 32;
    localparam int L_MASK_LB  = 0;
    localparam int L_MASK_LH  = 1;
    localparam int L_MASK_LW  = 2;
    localparam int L_MASK_LBU = 3;
    localparam int L_MASK_LHU = 4;
    localparam logic [3:0] BWE_B0 = 4'b0001;
    localparam logic [3:0] BWE_B1 = 4'b0010;
    localparam logic [3:0] BWE_B2 = 4'b0100;
    localparam logic [3:0] BWE_B3 = 4'b1000;
    localparam logic [3:0] BWE_H0 = 4'b0011;
    localparam logic [3:0] BWE_H1 = 4'b1100;
    localparam logic [3:0] BWE_W  = 4'b1111;

    typedef enum logic {IDLE, WAIT} state_t;

    function automatic logic misaligned(input logic [1:0] off, input logic [4:0] mask,
                                        input logic [3:0] bwe, input logic we);
        return we ? ((((bwe == BWE_H0) || (bwe == BWE_H1)) && off[0]) || ((bwe == BWE_W) && (off != 2'b00)))
                  : (((mask[L_MASK_LH] || mask[L_MASK_LHU]) && off[0]) || (mask[L_MASK_LW] && (off != 2'b00)));
    endfunction
endpackage

// File: rtl/dmem_resp_if.sv
// dmem_resp_if: load/store request and response bundle between execute stage and data memory
interface dmem_resp_if #(parameter int XLEN = 32);
    logic            req_re;
    logic            req_we;
    logic [XLEN-1:0] req_addr;
    logic [4:0]      req_l_mask;
    logic [3:0]      req_byte_we;
    logic [XLEN-1:0] req_wdata;
    logic            req_ready;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            misalign_exp;
    logic [XLEN-1:0] misalign_addr;

    modport master(output req_re, req_we, req_addr, req_l_mask, req_byte_we, req_wdata,
                   input req_ready, rsp_valid, rsp_rdata, misalign_exp, misalign_addr);
    modport slave(input req_re, req_we, req_addr, req_l_mask, req_byte_we, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata, misalign_exp, misalign_addr);
endinterface

// File: rtl/dmem_resp_load_ext.sv
// dmem_resp_load_ext: picks the addressed byte/half of a RAM word and sign/zero extends it
module dmem_resp_load_ext
    import dmem_resp_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [4:0]  i_mask,
    output logic [31:0] o_data
);
    logic [7:0]  w_b;
    logic [15:0] w_h;

    assign w_b = i_word[8*i_off +: 8];
    assign w_h = i_off[1] ? i_word[31:16] : i_word[15:0];

    always_comb
        o_data = i_mask[L_MASK_LB]  ? {{24{w_b[7]}}, w_b} :
                 i_mask[L_MASK_LH]  ? {{16{w_h[15]}}, w_h} :
                 i_mask[L_MASK_LW]  ? i_word :
                 i_mask[L_MASK_LBU] ? {24'b0, w_b} :
                 i_mask[L_MASK_LHU] ? {16'b0, w_h} : 32'b0;
endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: word RAM answering load/store requests after WAIT_CYCLES, stalling while busy
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 1
) (
    input logic        clk,
    input logic        rst,
    dmem_resp_if.slave bus
);
    localparam bit         ZW   = (WAIT_CYCLES == 0);
    localparam logic [3:0] LAST = 4'(ZW ? 0 : WAIT_CYCLES - 1);

    logic [XLEN-1:0] r_ram [2**ADDR_W];
    state_t          r_state, w_next;
    logic [3:0]      r_cnt, w_cnt_next;
    logic [XLEN-1:0] r_addr, r_wdata, r_rdata, r_maddr;
    logic [4:0]      r_mask;
    logic [3:0]      r_bwe;
    logic            r_we, r_valid, r_mis;
    logic            w_accept, w_go, w_we, w_mis;
    logic [XLEN-1:0] w_addr, w_wdata, w_lane, w_ext;
    logic [4:0]      w_mask;
    logic [3:0]      w_bwe;
    logic [ADDR_W-1:0] w_idx;

    assign w_accept = (r_state == IDLE) && (bus.req_re || bus.req_we);
    // with no wait cycles the access uses the request as presented, otherwise the captured copy
    assign w_addr  = ZW ? bus.req_addr    : r_addr;
    assign w_wdata = ZW ? bus.req_wdata   : r_wdata;
    assign w_mask  = ZW ? bus.req_l_mask  : r_mask;
    assign w_bwe   = ZW ? bus.req_byte_we : r_bwe;
    assign w_we    = ZW ? bus.req_we      : r_we;
    assign w_go    = !rst && (ZW ? w_accept : (r_state == WAIT && r_cnt == LAST));
    assign w_mis   = misaligned(w_addr[1:0], w_mask, w_bwe, w_we);
    assign w_idx   = w_addr[ADDR_W+1:2];
    assign w_lane  = $onehot(w_bwe) ? {4{w_wdata[7:0]}} :
                     (w_bwe == BWE_H0 || w_bwe == BWE_H1) ? {2{w_wdata[15:0]}} : w_wdata;

    dmem_resp_load_ext u_ext (.i_word(r_ram[w_idx]), .i_off(w_addr[1:0]), .i_mask(w_mask), .o_data(w_ext));

    always_ff @(posedge clk)
        if (w_go && w_we && !w_mis)
            for (int i = 0; i < 4; i++)
                if (w_bwe[i]) r_ram[w_idx][8*i +: 8] <= w_lane[8*i +: 8];

    always_ff @(posedge clk)
        if (w_accept) begin
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_mask  <= bus.req_l_mask;
            r_bwe   <= bus.req_byte_we;
            r_we    <= bus.req_we;
        end

    always_ff @(posedge clk)
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_rdata <= '0;
            r_mis   <= 1'b0;
            r_maddr <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_valid <= w_go;
            r_rdata <= (w_go && !w_we && !w_mis) ? w_ext : '0;
            r_mis   <= w_go && w_mis;
            if (w_go && w_mis) r_maddr <= w_addr;
        end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        if (r_state == IDLE) begin
            w_next     = (w_accept && !ZW) ? WAIT : IDLE;
            w_cnt_next = '0;
        end else begin
            w_next     = (r_cnt == LAST) ? IDLE : WAIT;
            w_cnt_next = (r_cnt == LAST) ? 4'd0 : r_cnt + 4'd1;
        end
    end

    assign bus.req_ready     = (r_state == IDLE);
    assign bus.rsp_valid     = r_valid;
    assign bus.rsp_rdata     = r_rdata;
    assign bus.misalign_exp  = r_mis;
    assign bus.misalign_addr = r_maddr;
endmodule
